// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W     = 32;
    localparam int WAIT_CNT_W = 4;

    // Any nonzero low byte-offset means the access is not word-aligned.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return |byte_off;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - load/store request, response and stall bundle between EX/MEM and the responder
interface dmem_if
    import dmem_pkg::*;
    ();

    logic              req_valid;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_rdata;
    logic              stall;
    logic              err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, stall, err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, stall, err
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH x 32 word storage, synchronous write, registered read, async clear
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] rdata_d;

    // A store leaves the read register untouched so the last load data is held.
    always_comb begin
        mem_d   = mem_q;
        rdata_d = rdata_q;
        if (en) begin
            if (clr) begin
                rdata_d = '0;
            end else if (we) begin
                mem_d[idx] = wdata;
            end else begin
                rdata_d = mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with pipeline stall
// Optional misaligned-access error response enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic reset,
    dmem_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of two and at least 4");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_STATES must be in 0..15");
    end

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [AW+1:0]         addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;

    logic                  in_idle;
    logic                  accept;
    logic                  mem_en;
    logic                  acc_write;
    logic [AW+1:0]         acc_addr;
    logic [WORD_W-1:0]     acc_wdata;
    logic                  misalign;
    logic [WORD_W-1:0]     rdata;

    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle & bus.req_valid;

    // With zero wait states the array is accessed straight from the request inputs.
    always_comb begin
        if (in_idle) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr[AW+1:0];
            acc_wdata = bus.req_wdata;
        end else begin
            acc_write = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mem_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr[AW+1:0];
                    wdata_d = bus.req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        mem_en  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    mem_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = is_misaligned(acc_addr[1:0]);
    assign bus.err  = (state_q == RESP) & is_misaligned(addr_q[1:0]);
`else
    logic unused_byte_off;
    assign unused_byte_off = ^{acc_addr[1:0], addr_q[1:0]};
    assign misalign = 1'b0;
    assign bus.err  = 1'b0;
`endif

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (mem_en),
        .we    (acc_write & ~misalign),
        .clr   (misalign),
        .idx   (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (rdata)
    );

    assign bus.req_ready = in_idle;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata;
    assign bus.stall     = (in_idle & bus.req_valid) | (state_q == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at two wait-state settings
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int WS0   = 2;
    localparam int WS1   = 0;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    dmem_if bus0 ();
    dmem_if bus1 ();

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model [2][DEPTH];
    logic [31:0] last_rdata [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel != 0) ? bus1.req_ready : bus0.req_ready;
    endfunction
    function automatic logic get_rsp_valid(input int sel);
        return (sel != 0) ? bus1.rsp_valid : bus0.rsp_valid;
    endfunction
    function automatic logic get_stall(input int sel);
        return (sel != 0) ? bus1.stall : bus0.stall;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel != 0) ? bus1.err : bus0.err;
    endfunction
    function automatic logic [31:0] get_rdata(input int sel);
        return (sel != 0) ? bus1.rsp_rdata : bus0.rsp_rdata;
    endfunction

    task automatic drive(input int sel, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel != 0) begin
            bus1.req_valid = v; bus1.req_write = w; bus1.req_addr = a; bus1.req_wdata = d;
        end else begin
            bus0.req_valid = v; bus0.req_write = w; bus0.req_addr = a; bus0.req_wdata = d;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) model[s][i] = '0;
            last_rdata[s] = '0;
        end
    endtask

    // Called at negedge+1; returns at negedge+1 of the response cycle.
    task automatic access(input int sel, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          k;
        int          n;
        int          ws;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        ws = (sel != 0) ? WS1 : WS0;
        drive(sel, 1'b1, w, a, d);
        #1;
        k = 0;
        while (!get_ready(sel) && k < 4) begin
            chk({tag, "/stall_in_resp"}, 32'(get_stall(sel)), 32'd0);
            @(negedge clk); #1;
            k++;
        end
        chk({tag, "/ready"}, 32'(get_ready(sel)), 32'd1);
        chk({tag, "/stall_accept"}, 32'(get_stall(sel)), 32'd1);
        idx     = int'((a >> 2) % DEPTH);
        exp_err = ALIGN && (a[1:0] != 2'b00);
        if (exp_err) last_rdata[sel] = '0;
        else if (w) model[sel][idx] = d;
        else last_rdata[sel] = model[sel][idx];
        exp_rd = last_rdata[sel];
        @(negedge clk);
        drive(sel, 1'b0, 1'($urandom), $urandom, $urandom);
        #1;
        n = 1;
        while (!get_rsp_valid(sel) && n < 40) begin
            chk({tag, "/stall_busy"}, 32'(get_stall(sel)), 32'd1);
            chk({tag, "/ready_busy"}, 32'(get_ready(sel)), 32'd0);
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "/rsp_valid"}, 32'(get_rsp_valid(sel)), 32'd1);
        chk({tag, "/latency"}, 32'(n), 32'(ws + 1));
        chk({tag, "/stall_resp"}, 32'(get_stall(sel)), 32'd0);
        chk({tag, "/ready_resp"}, 32'(get_ready(sel)), 32'd0);
        chk({tag, "/rdata"}, get_rdata(sel), exp_rd);
        chk({tag, "/err"}, 32'(get_err(sel)), 32'(exp_err));
    endtask

    task automatic idle_check(input int sel, input string tag);
        drive(sel, 1'b0, 1'b0, '0, '0);
        @(negedge clk); #1;
        chk({tag, "/ready_idle"}, 32'(get_ready(sel)), 32'd1);
        chk({tag, "/rsp_idle"}, 32'(get_rsp_valid(sel)), 32'd0);
        chk({tag, "/stall_idle"}, 32'(get_stall(sel)), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        model_reset();
        @(negedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset/ready", 32'(get_ready(s)), 32'd1);
            chk("reset/rsp_valid", 32'(get_rsp_valid(s)), 32'd0);
            chk("reset/rdata", get_rdata(s), 32'd0);
            chk("reset/err", 32'(get_err(s)), 32'd0);
            chk("reset/stall", 32'(get_stall(s)), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;

        access(0, 1'b0, 32'h10, 32'h0, "t1_load");
        idle_check(0, "t1");

        access(0, 1'b1, 32'h20, 32'hDEADBEEF, "t2_store");
        access(0, 1'b0, 32'h20, 32'h0, "t2_load");
        access(0, 1'b1, 32'h400, 32'hCAFEF00D, "t3_store");
        access(0, 1'b0, 32'h000, 32'h0, "t3_load");
        idle_check(0, "t3");

        drive(0, 1'b1, 1'b1, 32'h30, 32'h1234);
        #1;
        chk("t4/ready", 32'(get_ready(0)), 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("t4/stall_busy", 32'(get_stall(0)), 32'd1);
        reset = 1'b1;
        #1;
        chk("t4/rsp_in_reset", 32'(get_rsp_valid(0)), 32'd0);
        chk("t4/ready_in_reset", 32'(get_ready(0)), 32'd1);
        chk("t4/rdata_in_reset", get_rdata(0), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t4/no_rsp_after_reset", 32'(get_rsp_valid(0)), 32'd0);
        end
        access(0, 1'b0, 32'h30, 32'h0, "t4_load");
        idle_check(0, "t4");

        access(1, 1'b1, 32'h20, 32'h55, "t5_store");
        access(1, 1'b0, 32'h20, 32'h0, "t5_load");
        idle_check(1, "t5");

        access(0, 1'b1, 32'h20, 32'h0BADF00D, "t6_prior");
        access(0, 1'b1, 32'h22, 32'hFFFF, "t6_store_mis");
        access(0, 1'b0, 32'h20, 32'h0, "t6_load");
        idle_check(0, "t6");

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            a[9:6] = 4'h0;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            access(0, 1'($urandom), a, $urandom, "rand0");
        end
        idle_check(0, "rand0");
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            a[9:5] = 5'h0;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            access(1, 1'($urandom), a, $urandom, "rand1");
        end
        idle_check(1, "rand1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
